ch_readout_collector: RTL and testbench
=======================================

// Module: ch_readout_collector
// PURPOSE
//  Controller-side receiver for the per-channel counter serial readout. Pulses INST_READOUT to
//  snapshot the channel counters, then steps SELECT_REG 0..6 and deserialises CNT_SER (8 bits
//  per select, MSB-first) into a 56-bit word. Unpacks {pad[2:0],trigger_cnt,CE,CD,CC,CB,CA}.
//  Sits in the digital controller on SPI_CLK, one instance per channel readout link.
// PARAMETERS
//  NUM_BYTES      7  byte windows per readout (56 bits)
//  INST_HI_CYC    2  cycles INST_READOUT is held high
//  SETTLE_CYCLES  2  min cycles between INST_READOUT fall and first window
// PORTS
//  SPI_CLK      in   1   sole clock; same edge the channel serialiser uses
//  RST          in   1   synchronous, active-high reset; channel side held in reset by same source
//  START        in   1   1-cycle request to perform one readout
//  BUSY         out  1   high from cycle after accepted START until DONE
//  DONE         out  1   1-cycle pulse, result outputs valid from this cycle
//  INST_READOUT out  1   snapshot strobe to channel (channel captures on its rising edge)
//  SELECT_REG   out  3   byte select to channel
//  CNT_SER      in   1   serial bit from channel
//  TRIGGER_CNT  out  3   unpacked result; CE/CD/CC/CB/CA out 10 each
//  PAD_ERR      out  1   pad bits [55:53] nonzero in last readout
// BEHAVIOUR
//  - Reset (sync, RST=1): all outputs 0, FSM IDLE, phase=0, results cleared; overrides all else.
//  - phase: 3-bit free-running counter, +1 every cycle, wraps 7->0; mirrors channel ser_pos,
//    which starts at 0 on the same reset release. Window = 8 cycles with phase 0..7.
//  - Channel output is registered: bit k of the window (phase k) appears on CNT_SER in phase k+1
//    (k=7 -> phase 0 of next window). Collector samples CNT_SER every SHIFT cycle, shift-left.
//  - SELECT_REG registered; changes only on the edge leaving phase 7, stable across a window.
//  - FSM: IDLE -> STROBE -> SETTLE -> SHIFT -> FLUSH -> IDLE.
//    IDLE: START=1 -> STROBE, BUSY=1. START while BUSY ignored (no queueing).
//    STROBE: INST_READOUT=1 for INST_HI_CYC cycles, then 0 -> SETTLE.
//    SETTLE: count >= SETTLE_CYCLES AND phase==7 -> SHIFT, SELECT_REG<=0.
//    SHIFT: capture at phase 1..7 (bits 0..6) and following phase 0 (bit 7); byte s stored in
//      word[55-8s -: 8]; at phase 7 SELECT_REG<=s+1. After byte 6 window -> FLUSH.
//    FLUSH: captures last bit (phase 0), unpacks word, DONE=1, BUSY=0 next cycle -> IDLE.
//  - Latency START->DONE: 1+INST_HI_CYC+wait-to-phase-7+56+1 cycles; max 8 cycles of alignment.
//  - Unpack: word[52:50]=TRIGGER_CNT, [49:40]=CE, [39:30]=CD, [29:20]=CC, [19:10]=CB, [9:0]=CA.
//  - Results hold until next DONE; START on DONE cycle accepted (back-to-back readouts).
//  - SELECT_REG returns to 0 in IDLE; INST_READOUT never high outside STROBE.
// CONFIGURATION
//  CH_COLLECT_PAD_CHECK_EN defined: PAD_ERR <= |word[55:53] at DONE, held until next DONE.
//  Not defined: PAD_ERR tied 0, pad bits discarded, no check logic.
// STRUCTURE
//  ch_readout_pkg: state enum (IDLE,STROBE,SETTLE,SHIFT,FLUSH), BYTE_W=8, WORD_W=56,
//    field width/offset localparams (PAD, TRIG, CE..CA) shared with channel-side model.
//  Sub-module ch_ser_byte_shifter: 8-bit MSB-first shift reg + byte_valid, driven by phase.
// TESTING
//  1 Reset mid-SHIFT (RST at byte 3) -> next cycle BUSY=0, SELECT_REG=0, INST_READOUT=0, outputs 0.
//  2 Channel model trig=3'b101, CE=10'h3FF, CD=0, CC=10'h155, CB=10'h2AA, CA=10'h001, START
//    -> DONE once, outputs match exactly, PAD_ERR=0.
//  3 START asserted at each of phase 0..7 -> identical results; START->DONE latency in
//    [1+INST_HI_CYC+SETTLE_CYCLES+57, +8 more].
//  4 START held high 200 cycles -> back-to-back readouts, START during BUSY ignored, 1 DONE/readout.
//  5 Counters change 1 cycle after INST_READOUT rise -> collected values are pre-change snapshot.
//  6 CH_COLLECT_PAD_CHECK_EN on, model forces pad=3'b010 -> PAD_ERR=1; macro off -> PAD_ERR=0.

Source files
------------

// File: rtl/ch_readout_pkg.sv
// rtl/ch_readout_pkg.sv - shared constants, field layout and FSM states for the channel readout link
package ch_readout_pkg;

  localparam int NUM_BYTES     = 7;
  localparam int INST_HI_CYC   = 2;
  localparam int SETTLE_CYCLES = 2;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 56;

  // Readout word layout: {pad, trigger_cnt, CE, CD, CC, CB, CA}
  localparam int PAD_W    = 3;
  localparam int PAD_LSB  = 53;
  localparam int TRIG_W   = 3;
  localparam int TRIG_LSB = 50;
  localparam int CNT_W    = 10;
  localparam int CE_LSB   = 40;
  localparam int CD_LSB   = 30;
  localparam int CC_LSB   = 20;
  localparam int CB_LSB   = 10;
  localparam int CA_LSB   = 0;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    SETTLE,
    SHIFT,
    FLUSH
  } state_t;

endpackage

// File: rtl/ch_ser_byte_shifter.sv
// rtl/ch_ser_byte_shifter.sv - MSB-first serial-to-byte shifter, byte completes on the phase-0 sample
module ch_ser_byte_shifter
  import ch_readout_pkg::*;
(
  input  logic              SPI_CLK,
  input  logic              RST,
  input  logic              shift_en,
  input  logic [2:0]        phase,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid
);

  logic [BYTE_W-1:0] shift_reg;

  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[BYTE_W-2:0], bit_in};
    end
  end

  // The eighth bit of a window arrives in phase 0 of the following window.
  assign byte_data  = {shift_reg[BYTE_W-2:0], bit_in};
  assign byte_valid = shift_en && (phase == 3'd0);

endmodule

// File: rtl/ch_readout_collector.sv
// rtl/ch_readout_collector.sv - per-channel counter readout collector; CH_COLLECT_PAD_CHECK_EN enables the pad-bit check
module ch_readout_collector
  import ch_readout_pkg::*;
#(
  parameter int NUM_BYTES_P     = NUM_BYTES,
  parameter int INST_HI_CYC_P   = INST_HI_CYC,
  parameter int SETTLE_CYCLES_P = SETTLE_CYCLES
) (
  input  logic             SPI_CLK,
  input  logic             RST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             INST_READOUT,
  output logic [2:0]       SELECT_REG,
  input  logic             CNT_SER,
  output logic [TRIG_W-1:0] TRIGGER_CNT,
  output logic [CNT_W-1:0] CE,
  output logic [CNT_W-1:0] CD,
  output logic [CNT_W-1:0] CC,
  output logic [CNT_W-1:0] CB,
  output logic [CNT_W-1:0] CA,
  output logic             PAD_ERR
);

  localparam logic [3:0] HI_CNT     = 4'(INST_HI_CYC_P);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_CYCLES_P);
  localparam logic [2:0] LAST_SEL   = 3'(NUM_BYTES_P - 1);

  state_t            state, state_nxt;
  logic [2:0]        phase;
  logic [3:0]        cnt, cnt_nxt;
  logic [2:0]        sel_nxt;
  logic [2:0]        wr_idx;
  logic              shift_en;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] word_full;

  // cnt counts cycles spent in the current state, including the present one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = SELECT_REG;
    case (state)
      IDLE: begin
        sel_nxt = 3'd0;
        cnt_nxt = 4'd0;
        if (START) begin
          state_nxt = STROBE;
          cnt_nxt   = 4'd1;
        end
      end
      STROBE: begin
        if (cnt >= HI_CNT) begin
          state_nxt = SETTLE;
          cnt_nxt   = 4'd1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SETTLE: begin
        if (cnt >= SETTLE_CNT && phase == 3'd7) begin
          state_nxt = SHIFT;
          sel_nxt   = 3'd0;
        end else if (cnt != 4'hF) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SHIFT: begin
        if (phase == 3'd7) begin
          if (SELECT_REG == LAST_SEL) begin
            state_nxt = FLUSH;
            sel_nxt   = 3'd0;
          end else begin
            sel_nxt = SELECT_REG + 3'd1;
          end
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Phase 0 of the first window still carries stale data from before the snapshot.
  assign shift_en  = (state == SHIFT && (phase != 3'd0 || SELECT_REG != 3'd0)) || (state == FLUSH);
  assign wr_idx    = (state == FLUSH) ? LAST_SEL : SELECT_REG - 3'd1;
  assign word_full = {word[WORD_W-1:BYTE_W], byte_data};

  ch_ser_byte_shifter u_shifter (
    .SPI_CLK    (SPI_CLK),
    .RST        (RST),
    .shift_en   (shift_en),
    .phase      (phase),
    .bit_in     (CNT_SER),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      phase        <= 3'd0;
      SELECT_REG   <= 3'd0;
      INST_READOUT <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      word         <= '0;
      TRIGGER_CNT  <= '0;
      CE           <= '0;
      CD           <= '0;
      CC           <= '0;
      CB           <= '0;
      CA           <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      phase        <= phase + 3'd1;
      SELECT_REG   <= sel_nxt;
      INST_READOUT <= (state_nxt == STROBE);
      BUSY         <= (state_nxt != IDLE);
      DONE         <= (state == FLUSH);
      if (byte_valid) begin
        for (int i = 0; i < NUM_BYTES_P; i++) begin
          if (wr_idx == 3'(i)) begin
            word[WORD_W-1-BYTE_W*i -: BYTE_W] <= byte_data;
          end
        end
      end
      if (state == FLUSH) begin
        TRIGGER_CNT <= word_full[TRIG_LSB +: TRIG_W];
        CE          <= word_full[CE_LSB +: CNT_W];
        CD          <= word_full[CD_LSB +: CNT_W];
        CC          <= word_full[CC_LSB +: CNT_W];
        CB          <= word_full[CB_LSB +: CNT_W];
        CA          <= word_full[CA_LSB +: CNT_W];
      end
    end
  end

`ifdef CH_COLLECT_PAD_CHECK_EN
  always_ff @(posedge SPI_CLK) begin
    if (RST) begin
      PAD_ERR <= 1'b0;
    end else if (state == FLUSH) begin
      PAD_ERR <= |word_full[PAD_LSB +: PAD_W];
    end
  end
`else
  logic unused_pad;
  assign unused_pad = ^word_full[PAD_LSB +: PAD_W];
  assign PAD_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_ch_readout_collector.sv
// tb/tb_ch_readout_collector.sv - directed self-checking bench with a channel-side serialiser model
module tb_ch_readout_collector;
  import ch_readout_pkg::*;

  logic        SPI_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        BUSY, DONE, INST_READOUT, PAD_ERR;
  logic [2:0]  SELECT_REG;
  logic        cnt_ser;
  logic [2:0]  TRIGGER_CNT;
  logic [9:0]  CE, CD, CC, CB, CA;

  int checks = 0;
  int errors = 0;

  logic [2:0]  live_pad, live_trig;
  logic [9:0]  live_ce, live_cd, live_cc, live_cb, live_ca;
  logic [2:0]  exp_pad, exp_trig;
  logic [9:0]  exp_ce, exp_cd, exp_cc, exp_cb, exp_ca;
  logic [55:0] live_word;
  logic [2:0]  ser_pos;
  logic        inst_d;
  logic [55:0] snap;
  int          lat;
  int          n;
  int          nd;
  int          lat_tab [8] = '{65, 64, 63, 62, 69, 68, 67, 66};

  assign live_word = {live_pad, live_trig, live_ce, live_cd, live_cc, live_cb, live_ca};

  always #5 SPI_CLK = ~SPI_CLK;

  ch_readout_collector dut (
    .SPI_CLK      (SPI_CLK),
    .RST          (RST),
    .START        (START),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .INST_READOUT (INST_READOUT),
    .SELECT_REG   (SELECT_REG),
    .CNT_SER      (cnt_ser),
    .TRIGGER_CNT  (TRIGGER_CNT),
    .CE           (CE),
    .CD           (CD),
    .CC           (CC),
    .CB           (CB),
    .CA           (CA),
    .PAD_ERR      (PAD_ERR)
  );

  function automatic logic ser_bit(input logic [55:0] w, input logic [2:0] sel, input logic [2:0] pos);
    int idx;
    idx = 55 - 8 * int'(sel) - int'(pos);
    return (idx >= 0) ? w[idx] : 1'b0;
  endfunction

  // Channel side: snapshot on INST_READOUT rise, registered serial output per select window.
  always @(posedge SPI_CLK) begin
    if (RST) begin
      ser_pos <= 3'd0;
      inst_d  <= 1'b0;
      snap    <= '0;
      cnt_ser <= 1'b0;
    end else begin
      ser_pos <= ser_pos + 3'd1;
      inst_d  <= INST_READOUT;
      if (INST_READOUT && !inst_d) snap <= live_word;
      cnt_ser <= ser_bit(snap, SELECT_REG, ser_pos);
    end
  end

  task automatic tick();
    @(posedge SPI_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_live(input logic [2:0] pad, input logic [2:0] trig, input logic [9:0] ce,
                          input logic [9:0] cd, input logic [9:0] cc, input logic [9:0] cb,
                          input logic [9:0] ca);
    live_pad = pad; live_trig = trig; live_ce = ce; live_cd = cd; live_cc = cc; live_cb = cb; live_ca = ca;
    exp_pad  = pad; exp_trig  = trig; exp_ce  = ce; exp_cd  = cd; exp_cc  = cc; exp_cb  = cb; exp_ca  = ca;
  endtask

  task automatic check_results(input string tag);
    logic exp_pad_err;
`ifdef CH_COLLECT_PAD_CHECK_EN
    exp_pad_err = |exp_pad;
`else
    exp_pad_err = 1'b0;
`endif
    chk({tag, "_trig"}, 32'(TRIGGER_CNT), 32'(exp_trig));
    chk({tag, "_ce"}, 32'(CE), 32'(exp_ce));
    chk({tag, "_cd"}, 32'(CD), 32'(exp_cd));
    chk({tag, "_cc"}, 32'(CC), 32'(exp_cc));
    chk({tag, "_cb"}, 32'(CB), 32'(exp_cb));
    chk({tag, "_ca"}, 32'(CA), 32'(exp_ca));
    chk({tag, "_pad_err"}, 32'(PAD_ERR), 32'(exp_pad_err));
  endtask

  // One START pulse; returns START->DONE latency. alter flips live counters a cycle after INST_READOUT rises.
  task automatic run_readout(input string tag, input bit alter, output int latency);
    bit saw_inst;
    bit altered;
    int inst_cyc;
    saw_inst = 0;
    altered  = 0;
    inst_cyc = 0;
    latency  = 0;
    START = 1'b1;
    do begin
      tick();
      latency++;
      if (latency == 1) begin
        START = 1'b0;
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      end
      if (alter && saw_inst && !altered) begin
        live_ce = ~live_ce; live_cd = ~live_cd; live_cc = ~live_cc;
        live_cb = ~live_cb; live_ca = ~live_ca; live_trig = ~live_trig;
        altered = 1;
      end
      if (INST_READOUT) inst_cyc++;
      saw_inst |= INST_READOUT;
    end while (!DONE && latency < 200);
    chk({tag, "_done_seen"}, 32'(DONE), 32'd1);
    chk({tag, "_inst_cycles"}, 32'(inst_cyc), 32'(INST_HI_CYC));
    check_results(tag);
    tick();
    chk({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_busy_after"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    set_live(3'd0, 3'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    RST = 1'b1;
    repeat (3) tick();
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_inst", 32'(INST_READOUT), 32'd0);
    chk("reset_sel", 32'(SELECT_REG), 32'd0);
    chk("reset_pad_err", 32'(PAD_ERR), 32'd0);
    chk("reset_ce", 32'(CE), 32'd0);
    RST = 1'b0;
    tick();

    // Basic readout with pad forced nonzero
    set_live(3'b010, 3'b101, 10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h001);
    run_readout("basic", 0, lat);

    // Reset in the middle of byte 3
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (SELECT_REG != 3'd3 && n < 100) begin
      tick();
      n++;
    end
    chk("midrst_sel3_reached", 32'(SELECT_REG), 32'd3);
    RST = 1'b1;
    tick();
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_sel", 32'(SELECT_REG), 32'd0);
    chk("midrst_inst", 32'(INST_READOUT), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_trig", 32'(TRIGGER_CNT), 32'd0);
    chk("midrst_ce", 32'(CE), 32'd0);
    chk("midrst_cc", 32'(CC), 32'd0);
    chk("midrst_ca", 32'(CA), 32'd0);
    chk("midrst_pad_err", 32'(PAD_ERR), 32'd0);
    RST = 1'b0;
    tick();

    // START at every phase: same data, latency depends only on alignment
    set_live(3'b000, 3'b011, 10'h2C1, 10'h0F0, 10'h3C3, 10'h00F, 10'h200);
    for (int p = 0; p < 8; p++) begin
      n = 0;
      while (ser_pos != 3'(p) && n < 16) begin
        tick();
        n++;
      end
      run_readout($sformatf("phase%0d", p), 0, lat);
      chk($sformatf("phase%0d_latency", p), 32'(lat), 32'(lat_tab[p]));
      chk($sformatf("phase%0d_lat_range", p), 32'(lat >= 62 && lat <= 70), 32'd1);
    end

    // Counters move after the snapshot strobe: old values must be collected
    set_live(3'b000, 3'b110, 10'h123, 10'h0AB, 10'h3CD, 10'h001, 10'h2FE);
    run_readout("snapshot", 1, lat);

    // START held high for 200 cycles from phase 1: readouts every 64 cycles
    set_live(3'b000, 3'b001, 10'h111, 10'h222, 10'h333, 10'h044, 10'h155);
    n = 0;
    while (ser_pos != 3'd1 && n < 16) begin
      tick();
      n++;
    end
    nd = 0;
    START = 1'b1;
    for (int i = 1; i <= 330; i++) begin
      tick();
      if (i == 200) START = 1'b0;
      if (DONE) begin
        nd++;
        chk("b2b_done_time", 32'(i), 32'(64 * nd));
        check_results("b2b");
      end
    end
    chk("b2b_done_count", 32'(nd), 32'd4);
    chk("b2b_idle_busy", 32'(BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
